fetch_stage: RTL and testbench

- Instruction-fetch stage of the mini-rv in-order pipeline.
- Keeps the PC and issues one-at-a-time requests to instruction memory.
- Drives the if_id_* interface consumed by decode_stage: instruction word plus PC, with bubbles encoded as NOP.
- Accepts the stall from the hazard logic and the branch/jump redirect from execute.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: mini-rv instruction fetch with a one-outstanding imem port, stall hold buffer and redirect flush.
// Define FETCH_ALIGN_EN to force redirect targets to word alignment.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_if_redirect,
    input  logic [31:0] ex_if_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr_data,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, hold_data, hold_n, tgt, instr_n, ifpc_n;
    logic        kill, kill_n, valid_n, accept, load, in_flight;
`ifdef FETCH_ALIGN_EN
    assign tgt = {ex_if_target[31:2], 2'b00};
`else
    assign tgt = ex_if_target;
`endif
    assign imem_req  = (state == ISSUE) && !rst;
    assign imem_addr = pc;
    assign accept    = (state == WAIT) && imem_rvalid && !kill;
    assign load      = !ex_if_redirect && !stall && (accept || state == HOLD);
    // a redirect leaves a request in flight only if its response has not arrived yet
    assign in_flight = (state == ISSUE) || (state == WAIT && !imem_rvalid);
    always_comb begin
        state_n = state;
        kill_n  = kill;
        pc_n    = pc;
        hold_n  = hold_data;
        instr_n = if_id_instr_data;
        ifpc_n  = if_id_pc;
        valid_n = if_id_valid;
        if (ex_if_redirect) begin
            pc_n    = tgt;
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            kill_n  = in_flight;
            state_n = in_flight ? WAIT : ISSUE;
        end else begin
            if (load) begin
                instr_n = (state == HOLD) ? hold_data : imem_rdata;
                ifpc_n  = pc;
                valid_n = 1'b1;
                pc_n    = pc + 32'd4;
            end else if (!stall) begin
                instr_n = NOP_INSTR;
                valid_n = 1'b0;
            end
            case (state)
                ISSUE: state_n = WAIT;
                WAIT: if (imem_rvalid) begin
                    kill_n  = 1'b0;
                    hold_n  = (accept && stall) ? imem_rdata : hold_data;
                    state_n = (accept && stall) ? HOLD : ISSUE;
                end
                HOLD: state_n = stall ? HOLD : ISSUE;
                default: state_n = ISSUE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ISSUE;
            pc               <= RESET_PC;
            kill             <= 1'b0;
            hold_data        <= '0;
            if_id_instr_data <= NOP_INSTR;
            if_id_pc         <= '0;
            if_id_valid      <= 1'b0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            kill             <= kill_n;
            hold_data        <= hold_n;
            if_id_instr_data <= instr_n;
            if_id_pc         <= ifpc_n;
            if_id_valid      <= valid_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with 1-cycle memory models returning addr>>2.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_ALIGN_EN
    localparam logic [31:0] ALIGN_EXP = 32'h0000_0100;
`else
    localparam logic [31:0] ALIGN_EXP = 32'h0000_0102;
`endif
    logic        clk = 1'b0;
    logic        rst, stall, ex_if_redirect;
    logic [31:0] ex_if_target;
    logic        imem_req, imem_rvalid, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_instr_data, if_id_pc;
    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;
    int          tests = 0, fails = 0, w_nreq = 0, w_nout = 0;
    logic [31:0] addr_q[$];
    logic [63:0] out_q[$];

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_if_redirect(ex_if_redirect),
        .ex_if_target(ex_if_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .ex_if_redirect(1'b0),
        .ex_if_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_id_instr_data(w_instr), .if_id_pc(w_pc), .if_id_valid(w_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(imem_req === 1'b1 && imem_addr === a) && n < 60);
        tests++;
        if (!(imem_req === 1'b1 && imem_addr === a)) begin
            fails++;
            $display("FAIL wait_req: no request for %h, got req %b addr %h", a, imem_req, imem_addr);
        end
        #1;
    endtask

    task automatic wait_out(input logic [31:0] p);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(if_id_valid === 1'b1 && if_id_pc === p) && n < 60);
        tests++;
        if (!(if_id_valid === 1'b1 && if_id_pc === p)) begin
            fails++;
            $display("FAIL wait_out: pc %h never presented, got valid %b pc %h", p, if_id_valid, if_id_pc);
        end
        #1;
    endtask

    // memory for the main instance: request seen in one cycle answers in the next
    initial begin
        logic        p;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            p = imem_req && !rst;
            a = imem_addr;
            @(posedge clk);
            p = p && !rst;
            #1;
            imem_rvalid = p;
            imem_rdata  = a >> 2;
        end
    end

    // memory and checks for the wrap-around instance
    initial begin
        logic        p;
        logic [31:0] a;
        w_rvalid = 1'b0;
        w_rdata  = '0;
        forever begin
            @(negedge clk);
            p = w_req && !rst;
            a = w_addr;
            if (p && w_nreq < 2) begin
                chk("wrap_addr", w_addr, w_nreq == 0 ? 32'hFFFF_FFFC : 32'h0);
                w_nreq++;
            end
            if (!rst && w_valid && w_nout < 2) begin
                chk("wrap_pc", w_pc, w_nout == 0 ? 32'hFFFF_FFFC : 32'h0);
                chk("wrap_data", w_instr, w_nout == 0 ? 32'h3FFF_FFFF : 32'h0);
                w_nout++;
            end
            @(posedge clk);
            p = p && !rst;
            #1;
            w_rvalid = p;
            w_rdata  = a >> 2;
        end
    end

    // monitor: pops expected requests and if_id words as the DUT presents them
    initial begin
        logic        s, r, rr, pv;
        logic [31:0] lpc, ld;
        logic [63:0] e;
        pv = 1'b0; lpc = '0; ld = '0;
        forever begin
            @(posedge clk);
            s = stall; r = ex_if_redirect; rr = rst;
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
                end else chk("imem_addr", imem_addr, addr_q.pop_front());
            end
            if (if_id_valid !== 1'b1) chk("bubble_instr", if_id_instr_data, NOP);
            else if (s && !r && !rr && pv) begin
                chk("hold_pc", if_id_pc, lpc);
                chk("hold_data", if_id_instr_data, ld);
            end else if (out_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_out: pc %h data %h, none expected", if_id_pc, if_id_instr_data);
            end else begin
                e = out_q.pop_front();
                chk("out_pc", if_id_pc, e[63:32]);
                chk("out_data", if_id_instr_data, e[31:0]);
            end
            pv = if_id_valid; lpc = if_id_pc; ld = if_id_instr_data;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; ex_if_redirect = 1'b0; ex_if_target = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr_data, NOP);
        chk("rst_pc", if_id_pc, 0);
        chk("rst_addr", imem_addr, 0);
        addr_q.push_back(32'h0); addr_q.push_back(32'h4); addr_q.push_back(32'h8);
        out_q.push_back({32'h0, 32'h0}); out_q.push_back({32'h4, 32'h1}); out_q.push_back({32'h8, 32'h2});
        rst = 1'b0;
        // stall across the return of the word for pc 8
        wait_out(32'h4);
        stall = 1'b1;
        step();
        step();
        chk("no_req_in_hold", imem_req, 0);
        step();
        stall = 1'b0;
        // redirect during the issue cycle of pc 0x0C
        addr_q.push_back(32'hC); addr_q.push_back(32'h100);
        out_q.push_back({32'h100, 32'h40});
        wait_req(32'hC);
        ex_if_redirect = 1'b1; ex_if_target = 32'h100;
        step();
        ex_if_redirect = 1'b0;
        chk("redir_flush_valid", if_id_valid, 0);
        // redirect coinciding with rvalid while stalled
        addr_q.push_back(32'h104); addr_q.push_back(32'h200);
        out_q.push_back({32'h200, 32'h80});
        wait_req(32'h104);
        stall = 1'b1;
        step();
        chk("rvalid_seen", imem_rvalid, 1);
        ex_if_redirect = 1'b1; ex_if_target = 32'h200;
        step();
        ex_if_redirect = 1'b0;
        chk("stall_flush_valid", if_id_valid, 0);
        chk("stall_flush_instr", if_id_instr_data, NOP);
        chk("target_req", imem_req, 1);
        chk("target_addr", imem_addr, 32'h200);
        stall = 1'b0;
        // misaligned redirect target
        addr_q.push_back(32'h204); addr_q.push_back(ALIGN_EXP); addr_q.push_back(ALIGN_EXP + 32'd4);
        out_q.push_back({ALIGN_EXP, 32'h40});
        wait_req(32'h204);
        ex_if_redirect = 1'b1; ex_if_target = 32'h102;
        step();
        ex_if_redirect = 1'b0;
        wait_out(ALIGN_EXP);
        // reset while the request for ALIGN_EXP+4 is outstanding
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_valid", if_id_valid, 0);
        chk("midrst_pc", if_id_pc, 0);
        chk("midrst_instr", if_id_instr_data, NOP);
        chk("midrst_addr", imem_addr, 0);
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        out_q.push_back({32'h0, 32'h0});
        rst = 1'b0;
        wait_out(32'h0);
        chk("addr_q_drained", 32'(addr_q.size()), 0);
        chk("out_q_drained", 32'(out_q.size()), 0);
        chk("wrap_reqs", 32'(w_nreq), 2);
        chk("wrap_outs", 32'(w_nout), 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
